// File: rtl/bus_write_monitor_if.sv
// CPU-to-memory write bus as seen by passive observers.
// The core drives it through master; snoopers like bus_write_monitor use slave.
interface bus_write_monitor_if;
  logic [15:0] address;
  logic [7:0]  data;
  logic        memwrite;

  modport master (
    output address,
    output data,
    output memwrite
  );

  modport slave (
    input address,
    input data,
    input memwrite
  );
endinterface

// File: rtl/bus_write_monitor.sv
// Snoops CPU write cycles and raises a sticky pass/fail/timeout verdict,
// keeping write/cycle counters and a small ring of recent writes for debug.
module bus_write_monitor #(
  parameter logic [15:0] RESULT_ADDR    = 16'h0040,
  parameter logic [7:0]  EXPECTED       = 8'h33,
  parameter int unsigned TIMEOUT_CYCLES = 45,
  parameter int unsigned HIST_DEPTH     = 4
) (
  input  logic                          ph1,
  input  logic                          reset,
  bus_write_monitor_if.slave            bus,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [15:0]                   hist_addr,
  output logic [7:0]                    hist_data,
  output logic [7:0]                    write_count,
  output logic [15:0]                   cycle_count,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic                          timeout
);

  localparam int unsigned IdxW = $clog2(HIST_DEPTH);
  // Value of cycle_count during the last cycle allowed in RUN.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun,
    StPass,
    StFail,
    StTimeout
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      cycle_q, cycle_d;
  logic [7:0]       wcount_q, wcount_d;
  logic [IdxW-1:0]  wptr_q, wptr_d;
  logic             hist_we;
  logic [15:0]      hist_addr_q [HIST_DEPTH];
  logic [7:0]       hist_data_q [HIST_DEPTH];
  logic [IdxW-1:0]  rd_ptr;
  logic             result_write;

  assign result_write = bus.memwrite && (bus.address == RESULT_ADDR);

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    wcount_d = wcount_q;
    wptr_d   = wptr_q;
    hist_we  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (cycle_q != 16'hffff) begin
          cycle_d = cycle_q + 16'd1;
        end
        if (bus.memwrite) begin
          hist_we = 1'b1;
          wptr_d  = wptr_q + IdxW'(1);
          if (wcount_q != 8'hff) begin
            wcount_d = wcount_q + 8'd1;
          end
        end
        // A result write beats timeout expiry in the same cycle.
        if (result_write) begin
          state_d = (bus.data == EXPECTED) ? StPass : StFail;
        end else if (cycle_q == TimeoutLast) begin
          state_d = StTimeout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q  <= StRun;
      cycle_q  <= 16'h0000;
      wcount_q <= 8'h00;
      wptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      wcount_q <= wcount_d;
      wptr_q   <= wptr_d;
    end
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_addr_q[i] <= 16'h0000;
        hist_data_q[i] <= 8'h00;
      end
    end else if (hist_we) begin
      hist_addr_q[wptr_q] <= bus.address;
      hist_data_q[wptr_q] <= bus.data;
    end
  end

  // wptr_q points at the next free slot, so the newest entry sits one behind it.
  assign rd_ptr    = wptr_q - IdxW'(1) - hist_idx;
  assign hist_addr = hist_addr_q[rd_ptr];
  assign hist_data = hist_data_q[rd_ptr];

  assign write_count = wcount_q;
  assign cycle_count = cycle_q;
  assign done        = (state_q != StRun);
  assign pass        = (state_q == StPass);
  assign fail        = (state_q == StFail);
  assign timeout     = (state_q == StTimeout);

endmodule

// File: tb/tb_bus_write_monitor.sv
// Self-checking bench for bus_write_monitor: directed scenarios plus randomized
// write streams checked against a write-log reference model.
module tb_bus_write_monitor;

  localparam int TO = 45;

  logic        ph1;
  logic        reset;
  logic [1:0]  hist_idx;
  logic [15:0] hist_addr;
  logic [7:0]  hist_data;
  logic [7:0]  write_count;
  logic [15:0] cycle_count;
  logic        done, pass, fail, timeout;
  logic [3:0]  st;

  int n_checks = 0;
  int n_fail   = 0;

  bus_write_monitor_if bus ();

  bus_write_monitor dut (
    .ph1        (ph1),
    .reset      (reset),
    .bus        (bus),
    .hist_idx   (hist_idx),
    .hist_addr  (hist_addr),
    .hist_data  (hist_data),
    .write_count(write_count),
    .cycle_count(cycle_count),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout)
  );

  assign st = {done, pass, fail, timeout};

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic tick;
    @(posedge ph1);
    #1;
  endtask

  task automatic do_reset;
    bus.memwrite = 1'b0;
    bus.address  = 16'h0000;
    bus.data     = 8'h00;
    hist_idx     = 2'd0;
    reset        = 1'b1;
    @(posedge ph1);
    #1;
    reset = 1'b0;
  endtask

  task automatic bus_cycle(input logic w, input logic [15:0] a, input logic [7:0] d);
    bus.memwrite = w;
    bus.address  = a;
    bus.data     = d;
    tick();
    bus.memwrite = 1'b0;
  endtask

  task automatic test_reset;
    bus.memwrite = 1'b0;
    reset = 1'b1;
    #3;
    n_checks++;
    if (st !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", st);
    end
    n_checks++;
    if (write_count !== 8'd0 || cycle_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: got wc=%0d cc=%0d want 0/0", write_count, cycle_count);
    end
    for (int i = 0; i < 4; i++) begin
      hist_idx = 2'(i);
      #1;
      n_checks++;
      if (hist_addr !== 16'h0000 || hist_data !== 8'h00) begin
        n_fail++; $display("FAIL reset_hist[%0d]: got %h/%h want 0000/00", i, hist_addr, hist_data);
      end
    end
  endtask

  task automatic test_pass;
    do_reset();
    repeat (3) bus_cycle(1'b0, 16'h0040, 8'h33);
    n_checks++;
    if (st !== 4'b0000) begin
      n_fail++; $display("FAIL pass_idle: got %b want 0000", st);
    end
    bus_cycle(1'b1, 16'h0040, 8'h33);
    hist_idx = 2'd0;
    #1;
    n_checks++;
    if (st !== 4'b1100) begin
      n_fail++; $display("FAIL pass_flags: got %b want 1100", st);
    end
    n_checks++;
    if (write_count !== 8'd1 || cycle_count !== 16'd4) begin
      n_fail++; $display("FAIL pass_counts: got wc=%0d cc=%0d want 1/4", write_count, cycle_count);
    end
    n_checks++;
    if (hist_addr !== 16'h0040 || hist_data !== 8'h33) begin
      n_fail++; $display("FAIL pass_hist: got %h/%h want 0040/33", hist_addr, hist_data);
    end
  endtask

  task automatic test_fail;
    do_reset();
    bus_cycle(1'b1, 16'h0040, 8'h32);
    n_checks++;
    if (st !== 4'b1010) begin
      n_fail++; $display("FAIL fail_flags: got %b want 1010", st);
    end
    bus_cycle(1'b1, 16'h0040, 8'h33);
    n_checks++;
    if (st !== 4'b1010 || write_count !== 8'd1) begin
      n_fail++; $display("FAIL fail_sticky: got %b wc=%0d want 1010 wc=1", st, write_count);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    repeat (TO - 1) bus_cycle(1'b0, 16'h0000, 8'h00);
    n_checks++;
    if (st !== 4'b0000 || cycle_count !== 16'(TO - 1)) begin
      n_fail++; $display("FAIL timeout_early: got %b cc=%0d want 0000 cc=%0d", st, cycle_count, TO - 1);
    end
    bus_cycle(1'b0, 16'h0000, 8'h00);
    n_checks++;
    if (st !== 4'b1001 || cycle_count !== 16'(TO)) begin
      n_fail++; $display("FAIL timeout_edge: got %b cc=%0d want 1001 cc=%0d", st, cycle_count, TO);
    end
    bus_cycle(1'b1, 16'h0040, 8'h33);
    repeat (3) bus_cycle(1'b0, 16'h0000, 8'h00);
    n_checks++;
    if (st !== 4'b1001 || cycle_count !== 16'(TO) || write_count !== 8'd0) begin
      n_fail++; $display("FAIL timeout_frozen: got %b cc=%0d wc=%0d want 1001 cc=%0d wc=0",
                         st, cycle_count, write_count, TO);
    end
  endtask

  task automatic test_tie;
    do_reset();
    repeat (TO - 1) bus_cycle(1'b0, 16'h0000, 8'h00);
    bus_cycle(1'b1, 16'h0040, 8'h33);
    n_checks++;
    if (st !== 4'b1100 || write_count !== 8'd1) begin
      n_fail++; $display("FAIL tie: got %b wc=%0d want 1100 wc=1", st, write_count);
    end
  endtask

  task automatic test_history_wrap;
    logic [15:0] ea [4];
    logic [7:0]  ed [4];
    ea = '{16'h0040, 16'h0014, 16'h0013, 16'h0012};
    ed = '{8'h33, 8'h05, 8'h04, 8'h03};
    do_reset();
    for (int i = 0; i < 5; i++) bus_cycle(1'b1, 16'h0010 + 16'(i), 8'(i + 1));
    // Glitch on memwrite between edges must not be sampled.
    bus.memwrite = 1'b1; bus.address = 16'h0040; bus.data = 8'h00;
    #2;
    bus.memwrite = 1'b0;
    bus_cycle(1'b1, 16'h0040, 8'h33);
    n_checks++;
    if (write_count !== 8'd6 || st !== 4'b1100) begin
      n_fail++; $display("FAIL hist_count: got wc=%0d st=%b want 6 1100", write_count, st);
    end
    for (int i = 0; i < 4; i++) begin
      hist_idx = 2'(i);
      #1;
      n_checks++;
      if (hist_addr !== ea[i] || hist_data !== ed[i]) begin
        n_fail++; $display("FAIL hist_wrap[%0d]: got %h/%h want %h/%h",
                           i, hist_addr, hist_data, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    bus_cycle(1'b1, 16'h0100, 8'hA5);
    bus_cycle(1'b1, 16'h0041, 8'h33);
    n_checks++;
    if (write_count !== 8'd2 || st !== 4'b0000) begin
      n_fail++; $display("FAIL async_pre: got wc=%0d st=%b want 2 0000", write_count, st);
    end
    #2;
    reset = 1'b1;
    #1;
    hist_idx = 2'd0;
    #1;
    n_checks++;
    if (st !== 4'b0000 || write_count !== 8'd0 || cycle_count !== 16'd0 ||
        hist_addr !== 16'h0000 || hist_data !== 8'h00) begin
      n_fail++; $display("FAIL async_clear: got st=%b wc=%0d cc=%0d h=%h/%h want all zero",
                         st, write_count, cycle_count, hist_addr, hist_data);
    end
    @(posedge ph1);
    #1;
    reset = 1'b0;
    bus_cycle(1'b1, 16'h0040, 8'h33);
    n_checks++;
    if (st !== 4'b1100 || write_count !== 8'd1 || cycle_count !== 16'd1) begin
      n_fail++; $display("FAIL async_repass: got st=%b wc=%0d cc=%0d want 1100 1 1",
                         st, write_count, cycle_count);
    end
  endtask

  // Model: the verdict is decided by the first write to the result address if it
  // lands within the first TO cycles, otherwise timeout at cycle TO; everything
  // after that cycle is ignored. History is the tail of the logged-write list.
  task automatic test_random;
    for (int t = 0; t < 24; t++) begin
      int len, vcyc, verdict, exp_wc, sel;
      logic        w [];
      logic [15:0] a [];
      logic [7:0]  d [];
      logic [23:0] log_q [$];
      logic [3:0]  exp_st;
      len = $urandom_range(70, 1);
      w = new[len]; a = new[len]; d = new[len];
      for (int i = 0; i < len; i++) begin
        w[i] = ($urandom_range(99, 0) < 40);
        sel  = $urandom_range(19, 0);
        a[i] = (sel == 0) ? 16'h0040 : (sel == 1) ? 16'h003f : (sel == 2) ? 16'h0041 :
               16'($urandom);
        d[i] = ($urandom_range(1, 0) == 1) ? 8'h33 : 8'($urandom);
      end
      verdict = 0;
      vcyc = len;
      for (int i = 0; i < len; i++) begin
        if (w[i] && a[i] == 16'h0040 && i < TO) begin
          verdict = (d[i] == 8'h33) ? 1 : 2;
          vcyc = i + 1;
          break;
        end
      end
      if (verdict == 0 && len >= TO) begin
        verdict = 3;
        vcyc = TO;
      end
      for (int i = 0; i < vcyc; i++) if (w[i]) log_q.push_back({a[i], d[i]});
      exp_wc = log_q.size();
      exp_st = (verdict == 0) ? 4'b0000 : {1'b1, verdict == 1, verdict == 2, verdict == 3};

      do_reset();
      for (int i = 0; i < len; i++) bus_cycle(w[i], a[i], d[i]);
      n_checks++;
      if (st !== exp_st || write_count !== 8'(exp_wc) || cycle_count !== 16'(vcyc)) begin
        n_fail++; $display("FAIL rand%0d_state: got st=%b wc=%0d cc=%0d want st=%b wc=%0d cc=%0d",
                           t, st, write_count, cycle_count, exp_st, exp_wc, vcyc);
      end
      for (int k = 0; k < 4; k++) begin
        logic [23:0] e;
        e = (k < exp_wc) ? log_q[exp_wc - 1 - k] : 24'h0;
        hist_idx = 2'(k);
        #1;
        n_checks++;
        if ({hist_addr, hist_data} !== e) begin
          n_fail++; $display("FAIL rand%0d_hist[%0d]: got %h/%h want %h/%h",
                             t, k, hist_addr, hist_data, e[23:8], e[7:0]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    hist_idx = 2'd0;
    bus.memwrite = 1'b0;
    bus.address = 16'h0000;
    bus.data = 8'h00;
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_tie();
    test_history_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
